// File: rtl/game_io_hub.sv
// Memory-mapped IO hub: debounced per-player controller buttons with sticky press bits,
// rumble/LED outputs and double-buffered sprite words committed on vertical sync.
module game_io_hub #(
    parameter int unsigned NUM_PLAYERS     = 2,
    parameter int unsigned BTN_BITS        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic                            clock,
    input  logic                            reset_btn,
    input  logic [12:0]                     address,
    input  logic [31:0]                     data_in,
    input  logic                            wren,
    output logic [31:0]                     data_out,
    output logic                            io_hit,
    input  logic [NUM_PLAYERS*BTN_BITS-1:0] gpio_in,
    input  logic                            vsync,
    output logic [NUM_PLAYERS-1:0]          gpio_out,
    output logic [64*NUM_PLAYERS-1:0]       sprite_vga
);

    typedef logic [NUM_PLAYERS-1:0][BTN_BITS-1:0] btn_vec_t;
    localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);

    btn_vec_t                      gpio_s1_q, gpio_s2_q;
    logic                          vsync_s1_q, vsync_s2_q, vsync_prev_q;
    btn_vec_t                      cand_q, cand_d, level_q, level_d, press_q, press_d;
    logic [NUM_PLAYERS-1:0][15:0]  cnt_q, cnt_d;
    logic [NUM_PLAYERS-1:0][63:0]  shadow_q, shadow_d, sprite_q, sprite_d;
    logic [15:0]                   frame_q, frame_d;
    logic [NUM_PLAYERS-1:0]        gpio_out_q, gpio_out_d;
    logic [31:0]                   data_out_q, data_out_d;
    logic [31:0]                   rdata;
    logic [7:0]                    offset;
    logic                          commit;

    assign offset     = address[7:0];
    assign io_hit     = (address[12:8] == 5'h1F);
    assign commit     = vsync_s2_q & ~vsync_prev_q;
    assign data_out   = data_out_q;
    assign gpio_out   = gpio_out_q;
    assign sprite_vga = sprite_q;

    always_comb begin
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        press_d    = press_q;
        shadow_d   = shadow_q;
        sprite_d   = sprite_q;
        frame_d    = frame_q;
        gpio_out_d = gpio_out_q;
        rdata      = '0;

        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            // Any change restarts the stability count; level follows once it has held long enough.
            if (gpio_s2_q[p] != cand_q[p]) begin
                cand_d[p] = gpio_s2_q[p];
                cnt_d[p]  = '0;
            end else if (cnt_q[p] == CntMax) begin
                level_d[p] = cand_q[p];
            end else begin
                cnt_d[p] = cnt_q[p] + 16'd1;
            end

            if (offset == 8'(p)) begin
                rdata = 32'(level_q[p]);
            end
            if (offset == 8'(16 + p)) begin
                rdata = 32'(press_q[p]);
                if (io_hit && !wren) begin
                    press_d[p] = '0;
                end
            end
            // A rising edge in the clearing cycle survives the clear.
            press_d[p] = press_d[p] | (level_d[p] & ~level_q[p]);

            if (offset == 8'(32 + 2 * p)) begin
                rdata = shadow_q[p][31:0];
                if (io_hit && wren) begin
                    shadow_d[p][31:0] = data_in;
                end
            end
            if (offset == 8'(33 + 2 * p)) begin
                rdata = shadow_q[p][63:32];
                if (io_hit && wren) begin
                    shadow_d[p][63:32] = data_in;
                end
            end
        end

        if (offset == 8'h40) begin
            rdata = {16'h0000, frame_q};
        end
        if (offset == 8'h41) begin
            rdata = 32'(gpio_out_q);
            if (io_hit && wren) begin
                gpio_out_d = data_in[NUM_PLAYERS-1:0];
            end
        end

        // Commit copies the pre-write shadow, so a colliding write lands next frame.
        if (commit) begin
            sprite_d = shadow_q;
            frame_d  = frame_q + 16'd1;
        end

        data_out_d = io_hit ? rdata : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            gpio_s1_q    <= '0;
            gpio_s2_q    <= '0;
            vsync_s1_q   <= 1'b0;
            vsync_s2_q   <= 1'b0;
            vsync_prev_q <= 1'b0;
            cand_q       <= '0;
            cnt_q        <= '0;
            level_q      <= '0;
            press_q      <= '0;
            shadow_q     <= '0;
            sprite_q     <= '0;
            frame_q      <= '0;
            gpio_out_q   <= '0;
            data_out_q   <= '0;
        end else begin
            gpio_s1_q    <= gpio_in;
            gpio_s2_q    <= gpio_s1_q;
            vsync_s1_q   <= vsync;
            vsync_s2_q   <= vsync_s1_q;
            vsync_prev_q <= vsync_s2_q;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            press_q      <= press_d;
            shadow_q     <= shadow_d;
            sprite_q     <= sprite_d;
            frame_q      <= frame_d;
            gpio_out_q   <= gpio_out_d;
            data_out_q   <= data_out_d;
        end
    end

endmodule

// File: tb/tb_game_io_hub.sv
// Bench for game_io_hub: directed scenarios then random traffic, all checked every cycle
// against a run-length/array reference model of the hub.
module tb_game_io_hub;

    localparam int NP  = 2;
    localparam int DEB = 4;

    logic                clock = 1'b0;
    logic                rst_r = 1'b0;
    logic [12:0]         address = '0;
    logic [31:0]         data_in = '0;
    logic                wren = 1'b0;
    logic [31:0]         data_out;
    logic                io_hit;
    logic [NP*16-1:0]    gpio_r = '0;
    logic                vsync_r = 1'b0;
    logic [NP-1:0]       gpio_out;
    logic [64*NP-1:0]    sprite_vga;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [15:0]      m_level [NP];
    logic [15:0]      m_press [NP];
    logic [15:0]      m_lastv [NP];
    int               m_run [NP];
    logic [31:0]      m_shadow [NP][2];
    logic [63:0]      m_sprite [NP];
    logic [15:0]      m_frame = '0;
    logic [NP-1:0]    m_gout = '0;
    logic [31:0]      m_dout = '0;
    logic [NP*16-1:0] m_gh0 = '0, m_gh1 = '0;
    logic             m_vh0 = 1'b0, m_vh1 = 1'b0, m_vprev = 1'b0;

    game_io_hub #(
        .NUM_PLAYERS    (NP),
        .BTN_BITS       (16),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock     (clock),
        .reset_btn (rst_r),
        .address   (address),
        .data_in   (data_in),
        .wren      (wren),
        .data_out  (data_out),
        .io_hit    (io_hit),
        .gpio_in   (gpio_r),
        .vsync     (vsync_r),
        .gpio_out  (gpio_out),
        .sprite_vga(sprite_vga)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        int o = int'(off);
        if (o < NP) return {16'h0, m_level[o]};
        if (o >= 16 && o < 16 + NP) return {16'h0, m_press[o-16]};
        if (o >= 32 && o < 32 + 2 * NP) return m_shadow[(o-32)/2][(o-32)%2];
        if (o == 64) return {16'h0, m_frame};
        if (o == 65) return {30'h0, m_gout};
        return 32'h0;
    endfunction

    function automatic logic [127:0] exp_sprite();
        logic [127:0] v = '0;
        for (int p = 0; p < NP; p++) v[p*64 +: 64] = m_sprite[p];
        return v;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_level[p] = '0; m_press[p] = '0; m_lastv[p] = '0; m_run[p] = 1;
            m_shadow[p][0] = '0; m_shadow[p][1] = '0; m_sprite[p] = '0;
        end
        m_frame = '0; m_gout = '0; m_dout = '0;
        m_gh0 = '0; m_gh1 = '0; m_vh0 = 1'b0; m_vh1 = 1'b0; m_vprev = 1'b0;
    endtask

    // One clock edge of the hub as described behaviourally: a button level is accepted
    // once the synchronized value has been seen on DEB+1 consecutive edges.
    task automatic model_edge(input logic [12:0] a, input logic [31:0] d, input logic we);
        logic        hit;
        logic [7:0]  off;
        logic [15:0] used, nl, rise;
        logic [31:0] rd;
        logic        commit;
        int          o;
        if (!rst_r) begin
            model_reset();
            return;
        end
        hit    = (a[12:8] == 5'h1F);
        off    = a[7:0];
        o      = int'(off);
        rd     = hit ? model_read(off) : 32'h0;
        commit = m_vh1 && !m_vprev;
        for (int p = 0; p < NP; p++) begin
            used = m_gh1[p*16 +: 16];
            if (used == m_lastv[p]) m_run[p]++;
            else begin
                m_lastv[p] = used;
                m_run[p]   = 1;
            end
            nl   = (m_run[p] >= DEB + 1) ? m_lastv[p] : m_level[p];
            rise = nl & ~m_level[p];
            m_level[p] = nl;
            if (hit && !we && o == 16 + p) m_press[p] = '0;
            m_press[p] = m_press[p] | rise;
        end
        if (commit) begin
            for (int p = 0; p < NP; p++) m_sprite[p] = {m_shadow[p][1], m_shadow[p][0]};
            m_frame = m_frame + 16'd1;
        end
        if (hit && we) begin
            if (o >= 32 && o < 32 + 2 * NP) m_shadow[(o-32)/2][(o-32)%2] = d;
            if (o == 65) m_gout = d[NP-1:0];
        end
        m_vprev = m_vh1; m_vh1 = m_vh0; m_vh0 = vsync_r;
        m_gh1 = m_gh0; m_gh0 = gpio_r;
        m_dout = rd;
    endtask

    task automatic tick(input logic [12:0] a, input logic [31:0] d, input logic we);
        address = a;
        data_in = d;
        wren    = we;
        #1;
        check("io_hit", 128'(io_hit), 128'(a[12:8] == 5'h1F));
        @(posedge clock);
        model_edge(a, d, we);
        #1;
        check("data_out", 128'(data_out), 128'(m_dout));
        check("sprite_vga", 128'(sprite_vga), exp_sprite());
        check("gpio_out", 128'(gpio_out), 128'(m_gout));
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(13'h0000, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [12:0] a);
        tick(a, 32'h0, 1'b0);
    endtask

    logic [7:0] offs [16] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21,
                              8'h22, 8'h23, 8'h24, 8'h40, 8'h41, 8'h42, 8'h7F, 8'h10};

    initial begin
        model_reset();
        @(negedge clock);

        // Reset state.
        rst_r = 1'b0;
        idle(2);
        rst_r = 1'b1;
        check("reset_data_out", 128'(data_out), 128'(0));
        check("reset_sprite", 128'(sprite_vga), 128'(0));
        idle(3);

        // Debounce: 7-cycle press of player 0 bit 3.
        gpio_r[3] = 1'b1;
        idle(7);
        gpio_r[3] = 1'b0;
        rd(13'h1F00);
        check("deb_level", 128'(data_out), 128'(32'h8));
        rd(13'h1F10);
        check("deb_press", 128'(data_out), 128'(32'h8));
        rd(13'h1F10);
        check("deb_press_cleared", 128'(data_out), 128'(0));
        idle(10);
        gpio_r[3] = 1'b1;
        idle(2);
        gpio_r[3] = 1'b0;
        idle(10);
        rd(13'h1F00);
        check("glitch_level", 128'(data_out), 128'(0));
        rd(13'h1F10);
        check("glitch_press", 128'(data_out), 128'(0));

        // Read-clear race: the press lands on the edge of the 0x10 read.
        gpio_r[5] = 1'b1;
        idle(6);
        rd(13'h1F10);
        check("race_old", 128'(data_out), 128'(0));
        rd(13'h1F10);
        check("race_new", 128'(data_out), 128'(32'h20));
        gpio_r[5] = 1'b0;
        idle(10);

        // Double buffer commit latency.
        tick(13'h1F20, 32'h12345678, 1'b1);
        idle(3);
        check("db_hold", 128'(sprite_vga[31:0]), 128'(0));
        vsync_r = 1'b1;
        idle(2);
        check("db_pre_commit", 128'(sprite_vga[31:0]), 128'(0));
        idle(1);
        check("db_commit", 128'(sprite_vga[31:0]), 128'(32'h12345678));
        rd(13'h1F40);
        check("db_frame", 128'(data_out), 128'(1));

        // Commit collision on the high word.
        tick(13'h1F21, 32'h11111111, 1'b1);
        vsync_r = 1'b0; idle(3);
        vsync_r = 1'b1; idle(3);
        check("col_first", 128'(sprite_vga[63:32]), 128'(32'h11111111));
        vsync_r = 1'b0; idle(3);
        vsync_r = 1'b1; idle(2);
        tick(13'h1F21, 32'hDEADBEEF, 1'b1);
        check("col_keep_old", 128'(sprite_vga[63:32]), 128'(32'h11111111));
        vsync_r = 1'b0; idle(3);
        vsync_r = 1'b1; idle(3);
        check("col_next", 128'(sprite_vga[63:32]), 128'(32'hDEADBEEF));

        // Bounds.
        rd(13'h1F02);
        check("bad_player", 128'(data_out), 128'(0));
        rd(13'h0F00);
        check("outside_window", 128'(data_out), 128'(0));
        check("outside_hit", 128'(io_hit), 128'(0));

        // Frame counter wrap, preloaded near the top of its range.
        vsync_r = 1'b0; idle(3);
        force dut.frame_q = 16'hFFFE;
        m_frame = 16'hFFFE;
        idle(1);
        release dut.frame_q;
        vsync_r = 1'b1; idle(3);
        rd(13'h1F40);
        check("frame_ffff", 128'(data_out), 128'(32'hFFFF));
        vsync_r = 1'b0; idle(3);
        vsync_r = 1'b1; idle(3);
        rd(13'h1F40);
        check("frame_wrap", 128'(data_out), 128'(0));

        // Reset mid-operation.
        gpio_r[16+1] = 1'b1;
        idle(7);
        tick(13'h1F22, 32'hA5A5A5A5, 1'b1);
        tick(13'h1F41, 32'h3, 1'b1);
        vsync_r = 1'b0; idle(3);
        vsync_r = 1'b1; idle(3);
        gpio_r = '0;
        rst_r = 1'b0;
        tick(13'h1F41, 32'hF, 1'b1);
        rst_r = 1'b1;
        check("rst_gpio_out", 128'(gpio_out), 128'(0));
        check("rst_sprite", 128'(sprite_vga), 128'(0));
        rd(13'h1F11);
        check("rst_press", 128'(data_out), 128'(0));
        rd(13'h1F22);
        check("rst_shadow", 128'(data_out), 128'(0));
        rd(13'h1F41);
        check("rst_gout_rd", 128'(data_out), 128'(0));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [12:0] a;
            logic        we;
            if ($urandom_range(0, 9) == 0) begin
                int p = $urandom_range(0, NP - 1);
                int b = $urandom_range(0, 3);
                gpio_r[p*16 + b] = ~gpio_r[p*16 + b];
            end
            if ($urandom_range(0, 5) == 0) vsync_r = ~vsync_r;
            rst_r = ($urandom_range(0, 199) != 0);
            a = {5'h1F, offs[$urandom_range(0, 15)]};
            if ($urandom_range(0, 7) == 0) a[12:8] = 5'($urandom_range(0, 30));
            we = ($urandom_range(0, 2) == 0);
            tick(a, $urandom, we);
        end
        rst_r = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
